// File: rtl/fsa_acc_pkg.sv
// Shared types and constants for the streaming accumulator and its 27-bit adder.
package fsa_acc_pkg;

  localparam int unsigned OPW = 27;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  localparam logic [OPW-1:0] LO_RST  = '0;
  localparam logic [31:0]    HI_RST  = '0;
  localparam logic [31:0]    CNT_RST = '0;

endpackage

// File: rtl/csk_add27.sv
// Combinational 27-bit carry-skip adder, nine fixed 3-bit blocks, carry-in tied low.
module csk_add27
  import fsa_acc_pkg::*;
(
  output logic [OPW:0]   S,
  input  logic [OPW-1:0] X,
  input  logic [OPW-1:0] Y
);

  localparam int unsigned BLK  = 3;
  localparam int unsigned NBLK = OPW / BLK;

  logic [OPW-1:0] w_p;
  logic [OPW-1:0] w_g;
  logic [NBLK:0]  w_c;
  logic           w_rc;

  assign w_p = X ^ Y;
  assign w_g = X & Y;

  // Each block ripples internally; a fully propagating block passes its carry-in straight through.
  always_comb begin
    w_c  = '0;
    S    = '0;
    w_rc = 1'b0;
    for (int unsigned b = 0; b < NBLK; b++) begin
      w_rc = w_c[b];
      for (int unsigned k = 0; k < BLK; k++) begin
        S[b*BLK+k] = w_p[b*BLK+k] ^ w_rc;
        w_rc       = w_g[b*BLK+k] | (w_p[b*BLK+k] & w_rc);
      end
      w_c[b+1] = (&w_p[b*BLK +: BLK]) ? w_c[b] : w_rc;
    end
    S[OPW] = w_c[NBLK];
  end

endmodule

// File: rtl/fsa_stream_accumulator.sv
// Packet sum accumulator: 27-bit LO via carry-skip adder, carries counted into HI.
// Define FSA_ACC_SAT_EN to clamp {HI,LO} to all-ones on HI overflow instead of wrapping.
module fsa_stream_accumulator
  import fsa_acc_pkg::*;
#(
  parameter int unsigned HI_W  = 5,
  parameter int unsigned CNT_W = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [OPW-1:0]      IN_DATA,
  input  logic                IN_LAST,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [OPW+HI_W-1:0] OUT_SUM,
  output logic [CNT_W-1:0]    OUT_COUNT,
  output logic                OUT_OVF
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [OPW-1:0]   r_lo;
  logic [HI_W-1:0]  r_hi;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [OPW:0]     w_s;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_acc;
  logic             w_rel;
  logic             w_hi_wrap;

  csk_add27 u_add (
    .S (w_s),
    .X (r_lo),
    .Y (IN_DATA)
  );

  assign w_acc     = IN_VALID && w_in_ready;
  assign w_rel     = w_out_valid && OUT_READY;
  assign w_hi_wrap = w_s[OPW] && (&r_hi);

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b1;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: if (w_acc) w_state_nxt = IN_LAST ? DONE : ACC;
      ACC:  if (w_acc && IN_LAST) w_state_nxt = DONE;
      DONE: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b1;
        if (OUT_READY) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_lo    <= LO_RST;
      r_hi    <= HI_RST[HI_W-1:0];
      r_cnt   <= CNT_RST[CNT_W-1:0];
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rel) begin
        r_lo  <= LO_RST;
        r_hi  <= HI_RST[HI_W-1:0];
        r_cnt <= CNT_RST[CNT_W-1:0];
        r_ovf <= 1'b0;
      end else if (w_acc) begin
`ifdef FSA_ACC_SAT_EN
        // Once clamped, any nonzero beat re-triggers the clamp and a zero beat leaves LO unchanged.
        if (w_hi_wrap) begin
          r_lo <= '1;
          r_hi <= '1;
        end else begin
          r_lo <= w_s[OPW-1:0];
          if (w_s[OPW]) r_hi <= r_hi + 1'b1;
        end
`else
        r_lo <= w_s[OPW-1:0];
        if (w_s[OPW]) r_hi <= r_hi + 1'b1;
`endif
        if (!(&r_cnt)) r_cnt <= r_cnt + 1'b1;
        if (w_hi_wrap || (&r_cnt)) r_ovf <= 1'b1;
      end
    end
  end

  assign IN_READY  = w_in_ready;
  assign OUT_VALID = w_out_valid;
  assign OUT_SUM   = {r_hi, r_lo};
  assign OUT_COUNT = r_cnt;
  assign OUT_OVF   = r_ovf;

endmodule
